// File: rtl/axi4_master_wr_burst_engine.sv
// axi4_master_wr_burst_engine: command/beat streams to AXI4 AW/W/B write bursts
// with local rejection of illegal bursts and bounded outstanding tracking.
module axi4_master_wr_burst_engine #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_LEN         = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  output logic                    cmd_err,
  input  logic                    wdat_valid,
  output logic                    wdat_ready,
  input  logic [DATA_WIDTH-1:0]   wdat_data,
  input  logic [DATA_WIDTH/8-1:0] wdat_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_WIDTH-1:0]     rsp_id,
  output logic [1:0]              rsp_resp,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic [ID_WIDTH-1:0]     AWID,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  input  logic                    BVALID,
  output logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     BID,
  input  logic [1:0]              BRESP
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SZ = $clog2(NB);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'(NB - 1);
  typedef enum logic {W_IDLE, W_DATA} wst_e;
  wst_e            wst_q;
  logic [OW-1:0]   out_q, out_d, cnt_q;
  logic [PW-1:0]   wr_q, rd_q;
  logic [7:0]      beat_q;
  logic [7:0]      fifo_q [MAX_OUTSTANDING];
  logic [17:0]     end_b;
  logic            illegal, cmd_fire, acc, b_ok, w_fire, w_pop;
  // 18 bits holds 4095 + 256*128 without wrapping for every legal parameter set
  assign end_b     = {6'd0, cmd_addr[11:0]} + ({9'd0, {1'b0, cmd_len} + 9'd1} << SZ);
  assign illegal   = (|(cmd_addr & AMASK)) || ({1'b0, cmd_len} >= 9'(MAX_LEN)) || (end_b > 18'd4096);
  assign cmd_ready = !AWVALID && (out_q < OW'(MAX_OUTSTANDING));
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign acc       = cmd_fire && !illegal;
  assign BREADY    = !rsp_valid || rsp_ready;
  assign b_ok      = BVALID && BREADY && (out_q != '0);
  assign WVALID    = (wst_q == W_DATA) && wdat_valid;
  assign wdat_ready = (wst_q == W_DATA) && WREADY;
  assign WLAST     = (wst_q == W_DATA) && (beat_q == 8'd0);
  assign WDATA     = wdat_data;
  assign WSTRB     = wdat_strb;
  assign w_fire    = WVALID && WREADY;
  assign w_pop     = w_fire && WLAST;
  assign out_d     = out_q + OW'(acc) - OW'(b_ok);
  assign AWSIZE    = 3'(SZ);
  assign AWBURST   = 2'b01;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      AWVALID   <= 1'b0;
      AWADDR    <= '0;
      AWLEN     <= '0;
      AWID      <= '0;
      cmd_err   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_resp  <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      beat_q    <= '0;
      wst_q     <= W_IDLE;
    end else begin
      cmd_err <= cmd_fire && illegal;
      if (acc) begin
        AWVALID <= 1'b1;
        AWADDR  <= cmd_addr;
        AWLEN   <= cmd_len;
        AWID    <= cmd_id;
      end else if (AWREADY) AWVALID <= 1'b0;
      out_q <= out_d;
      cnt_q <= cnt_q + OW'(acc) - OW'(w_pop);
      if (acc) wr_q <= (wr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + 1'b1;
      if (w_pop) rd_q <= (rd_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + 1'b1;
      if (wst_q == W_IDLE) begin
        if (cnt_q != '0) begin
          beat_q <= fifo_q[rd_q];
          wst_q  <= W_DATA;
        end
      end else if (w_fire) begin
        if (WLAST) wst_q <= W_IDLE;
        else beat_q <= beat_q - 8'd1;
      end
      if (b_ok) begin
        rsp_valid <= 1'b1;
        rsp_id    <= BID;
        rsp_resp  <= BRESP;
      end else if (rsp_ready) rsp_valid <= 1'b0;
    end
  end
  always_ff @(posedge ACLK) if (acc) fifo_q[wr_q] <= cmd_len;
  // a B with nothing outstanding is dropped by b_ok; flag it in simulation
  a_no_underflow: assert property (@(posedge ACLK) disable iff (!ARESETn) !(BVALID && BREADY && out_q == '0));
endmodule

// File: tb/tb_axi4_master_wr_burst_engine.sv
// tb_axi4_master_wr_burst_engine: directed stimulus with a queue-based model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_axi4_master_wr_burst_engine;
  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_err;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat_data;
  logic [3:0]  wdat_strb;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_id;
  logic [1:0]  rsp_resp;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWID;
  logic        WVALID, WREADY, WLAST;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        wr_tog = 1'b0, wr_phase = 1'b0, wr_fix = 1'b1;
  always #5 ACLK = ~ACLK;
  assign WREADY = wr_tog ? wr_phase : wr_fix;
  always @(posedge ACLK) begin #1; wr_phase = !wr_phase; end
  axi4_master_wr_burst_engine dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_id(cmd_id), .cmd_err(cmd_err),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data), .wdat_strb(wdat_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP)
  );
  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [31:0] bdat(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction
  function automatic logic [3:0] bstr(input int i);
    return 4'(i * 5 + 3);
  endfunction
  typedef struct {logic [31:0] a; logic [7:0] l; logic [3:0] id;} aw_t;
  typedef struct {logic [3:0] id; logic [1:0] r;} rsp_t;
  aw_t  aw_q[$];
  rsp_t rq[$];
  int   wq[$];
  int   wb = 0, m = 0, k = 0, lastcnt = 0, cnt = 0;
  logic err_exp = 1'b0;
  bit   exp_cr, exp_br, ill, wf;
  // model: checks state after the last edge, then predicts the next edge
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      chk("rst_awvalid", AWVALID, 0);
      chk("rst_wvalid", WVALID, 0);
      chk("rst_wlast", WLAST, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_err", cmd_err, 0);
      aw_q.delete(); wq.delete(); rq.delete();
      wb = 0; cnt = 0; err_exp = 1'b0;
    end else begin
      exp_cr = aw_q.size() == 0 && cnt < 4;
      exp_br = rq.size() == 0 || rsp_ready;
      chk("awvalid", AWVALID, aw_q.size() != 0);
      if (aw_q.size() != 0) begin
        chk("awaddr", AWADDR, aw_q[0].a);
        chk("awlen", AWLEN, aw_q[0].l);
        chk("awid", AWID, aw_q[0].id);
      end
      chk("awsize", AWSIZE, 2);
      chk("awburst", AWBURST, 1);
      chk("cmd_ready", cmd_ready, exp_cr);
      chk("cmd_err", cmd_err, err_exp);
      chk("bready", BREADY, exp_br);
      chk("rsp_valid", rsp_valid, rq.size() != 0);
      if (rq.size() != 0) begin
        chk("rsp_id", rsp_id, rq[0].id);
        chk("rsp_resp", rsp_resp, rq[0].r);
      end
      if (WVALID) begin
        chk("w_without_burst", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          chk("wdata", WDATA, bdat(m));
          chk("wstrb", WSTRB, bstr(m));
          chk("wlast", WLAST, wb == wq[0]);
        end
      end
      err_exp = 1'b0;
      if (AWVALID && AWREADY && aw_q.size() != 0) void'(aw_q.pop_front());
      if (WVALID && WREADY && wq.size() != 0) begin
        m++;
        if (wb == wq[0]) begin void'(wq.pop_front()); wb = 0; lastcnt++; end
        else wb++;
      end
      if (rq.size() != 0 && rsp_ready) void'(rq.pop_front());
      if (BVALID && exp_br && cnt > 0) begin rq.push_back(rsp_t'{BID, BRESP}); cnt--; end
      if (cmd_valid && exp_cr) begin
        ill = (cmd_addr % 4) != 0 || int'(cmd_len) + 1 > 16 ||
              int'(cmd_addr % 4096) + (int'(cmd_len) + 1) * 4 > 4096;
        if (ill) err_exp = 1'b1;
        else begin
          aw_q.push_back(aw_t'{cmd_addr, cmd_len, cmd_id});
          wq.push_back(int'(cmd_len));
          cnt++;
        end
      end
    end
  end
  always begin
    @(negedge ACLK); #1;
    wf = wdat_valid && wdat_ready && ARESETn;
    @(posedge ACLK); #1;
    if (wf) begin k++; wdat_data = bdat(k); wdat_strb = bstr(k); end
  end
  task automatic step();
    @(posedge ACLK); #1;
  endtask
  task automatic neg();
    @(negedge ACLK);
  endtask
  task automatic tick(input int n);
    repeat (n) step();
  endtask
  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    int t = 0;
    cmd_addr = a; cmd_len = l; cmd_id = id; cmd_valid = 1'b1;
    neg();
    while (!cmd_ready && t < 100) begin t++; neg(); end
    chk("cmd_accept_timeout", t < 100, 1);
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic send_b(input logic [3:0] id, input logic [1:0] r);
    int t = 0;
    BID = id; BRESP = r; BVALID = 1'b1;
    neg();
    while (!BREADY && t < 100) begin t++; neg(); end
    chk("b_accept_timeout", t < 100, 1);
    step();
    BVALID = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (wq.size() != 0 && t < 300) begin neg(); #1; t++; end
    chk("w_drain_timeout", wq.size() == 0, 1);
    step();
  endtask
  logic [31:0] ia [3] = '{32'h0000_0FF8, 32'h0000_1002, 32'h0000_3000};
  logic [7:0]  il [3] = '{8'd3, 8'd0, 8'd16};
  int m0, l0;
  initial begin
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    wdat_valid = 0; wdat_data = bdat(0); wdat_strb = bstr(0);
    BVALID = 0; BID = 0; BRESP = 0; AWREADY = 1; rsp_ready = 1;
    repeat (3) @(posedge ACLK);
    neg();
    chk("rst_cmd_ready", cmd_ready, 1);
    step();
    ARESETn = 1'b1; wdat_valid = 1'b1;
    // single burst
    m0 = m; l0 = lastcnt;
    send_cmd(32'h1000, 8'd3, 4'd5);
    neg();
    chk("single_awvalid", AWVALID, 1);
    chk("single_awaddr", AWADDR, 32'h1000);
    chk("single_awlen", AWLEN, 3);
    chk("single_awid", AWID, 5);
    chk("single_awsize", AWSIZE, 2);
    chk("single_awburst", AWBURST, 2'b01);
    step();
    drain();
    chk("single_beats", m - m0, 4);
    chk("single_wlast_count", lastcnt - l0, 1);
    tick(2);
    send_b(4'd5, 2'd0);
    neg();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 5);
    chk("single_rsp_resp", rsp_resp, 0);
    step();
    // outstanding limit
    for (int i = 0; i < 4; i++) send_cmd(32'h2000 + 32'(i) * 32'h100, 8'd0, 4'(i));
    cmd_addr = 32'h2400; cmd_len = 0; cmd_id = 4'd9; cmd_valid = 1'b1;
    repeat (5) begin neg(); chk("full_cmd_ready", cmd_ready, 0); end
    step();
    BID = 4'd0; BRESP = 2'd0; BVALID = 1'b1;
    neg();
    chk("full_bready", BREADY, 1);
    chk("full_cmd_ready_at_b", cmd_ready, 0);
    step();
    BVALID = 1'b0;
    neg();
    chk("fifth_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    send_b(4'd1, 2'd0); send_b(4'd2, 2'd0); send_b(4'd3, 2'd0); send_b(4'd9, 2'd0);
    drain();
    // illegal commands, each followed by a legal one
    for (int i = 0; i < 3; i++) begin
      send_cmd(ia[i], il[i], 4'hE);
      neg();
      chk("ill_cmd_err", cmd_err, 1);
      chk("ill_awvalid", AWVALID, 0);
      step();
      neg();
      chk("ill_err_pulse", cmd_err, 0);
      chk("ill_cmd_ready", cmd_ready, 1);
      step();
      send_cmd(32'h7000, 8'd1, 4'd3);
      neg();
      chk("post_ill_awvalid", AWVALID, 1);
      step();
      drain();
      send_b(4'd3, 2'd0);
    end
    // legal boundaries: exact 4KB end and maximum length
    send_cmd(32'h0FF0, 8'd3, 4'd1);
    neg(); chk("edge_4k_err", cmd_err, 0); step();
    send_cmd(32'h8000, 8'd15, 4'd2);
    neg(); chk("maxlen_err", cmd_err, 0); step();
    drain();
    send_b(4'd1, 2'd0); send_b(4'd2, 2'd0);
    // backpressure
    wr_tog = 1'b1; m0 = m;
    send_cmd(32'hA000, 8'd3, 4'd7);
    send_cmd(32'hB000, 8'd3, 4'd8);
    drain();
    wr_tog = 1'b0;
    chk("bp_beats", m - m0, 8);
    rsp_ready = 1'b0;
    send_b(4'd7, 2'd2);
    BID = 4'd8; BRESP = 2'd1; BVALID = 1'b1;
    repeat (5) begin
      neg();
      chk("bp_bready", BREADY, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, 7);
      chk("bp_rsp_resp", rsp_resp, 2);
    end
    step();
    rsp_ready = 1'b1;
    neg(); chk("bp_bready_release", BREADY, 1);
    step();
    BVALID = 1'b0;
    neg();
    chk("bp_rsp2_valid", rsp_valid, 1);
    chk("bp_rsp2_id", rsp_id, 8);
    chk("bp_rsp2_resp", rsp_resp, 1);
    step();
    // simultaneous accept and B with two outstanding
    send_cmd(32'hC000, 8'd0, 4'd1);
    send_cmd(32'hC100, 8'd0, 4'd2);
    step();
    cmd_addr = 32'hC200; cmd_len = 0; cmd_id = 4'd3; cmd_valid = 1'b1;
    BID = 4'd1; BRESP = 2'd0; BVALID = 1'b1;
    neg();
    chk("sim_cmd_ready", cmd_ready, 1);
    chk("sim_bready", BREADY, 1);
    step();
    cmd_valid = 1'b0; BVALID = 1'b0;
    send_cmd(32'hC300, 8'd0, 4'd4);
    send_cmd(32'hC400, 8'd0, 4'd5);
    step();
    neg(); chk("sim_full_after_two", cmd_ready, 0);
    step();
    send_b(4'd2, 2'd0); send_b(4'd3, 2'd0); send_b(4'd4, 2'd0); send_b(4'd5, 2'd0);
    drain();
    // reset in the middle of a burst
    rsp_ready = 1'b0;
    send_cmd(32'hD000, 8'd0, 4'd3);
    drain();
    send_b(4'd3, 2'd0);
    AWREADY = 1'b0; m0 = m;
    send_cmd(32'hE000, 8'd3, 4'd4);
    begin
      int t = 0;
      while (m < m0 + 2 && t < 200) begin neg(); #1; t++; end
      chk("rst_beats_timeout", m >= m0 + 2, 1);
    end
    @(posedge ACLK); #2;
    chk("pre_rst_wvalid", WVALID, 1);
    chk("pre_rst_awvalid", AWVALID, 1);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    ARESETn = 1'b0;
    #1;
    chk("async_awvalid", AWVALID, 0);
    chk("async_wvalid", WVALID, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1; AWREADY = 1'b1; rsp_ready = 1'b1;
    m0 = m; l0 = lastcnt;
    send_cmd(32'hF000, 8'd1, 4'd6);
    drain();
    chk("post_rst_beats", m - m0, 2);
    chk("post_rst_wlast_count", lastcnt - l0, 1);
    send_b(4'd6, 2'd0);
    tick(3);
    chk("beats_conserved", m, k);
    chk("final_cmd_ready", cmd_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
